io_bus_arbiter: RTL and testbench

//  Shares the single io_register access port (addr/data_in/data_out/read/write/width) between
//  two requesters: CPU (port 0) and DMA engine (port 1). Latches one request at a time, drives
//  the io port for exactly one cycle, captures read data, returns a one-cycle ack. Round-robin

---
 rtl/fgba_io_pkg.sv | 20 ++
 rtl/io_rr_pick.sv | 81 ++++++++
 rtl/io_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fgba_io_pkg.sv
// Shared definitions for the io_register access path: width codes, requester IDs
// and the arbiter state encoding.
package fgba_io_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_id_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_ACK    = 2'b10
    } arb_state_t;

endpackage

// File: rtl/io_rr_pick.sv
// Two-way round-robin picker with a bounded DMA burst lock. Winner/valid are
// combinational; last_grant and burst_cnt advance only on an accepted grant.
module io_rr_pick
    import fgba_io_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic     clk_mem,
    input  logic     rst_n,
    input  logic [1:0] req,
    input  logic     dma_lock,
    input  logic     grant_en,
    output port_id_t winner,
    output logic     valid
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    port_id_t         last_grant_r;
    logic [CNT_W-1:0] burst_cnt_r;
    port_id_t         winner_s;
    logic             valid_s;
    logic             burst_ok_s;

    // Choose the winner for this IDLE cycle.
    always_comb begin
        burst_ok_s = dma_lock && (last_grant_r == PORT_DMA) && (burst_cnt_r < CNT_W'(MAX_BURST));
        winner_s   = PORT_CPU;
        valid_s    = 1'b0;
        case (req)
            2'b01: begin
                winner_s = PORT_CPU;
                valid_s  = 1'b1;
            end
            2'b10: begin
                winner_s = PORT_DMA;
                valid_s  = 1'b1;
            end
            2'b11: begin
                valid_s = 1'b1;
                if (burst_ok_s) begin
                    winner_s = PORT_DMA;
                end else if (last_grant_r == PORT_CPU) begin
                    winner_s = PORT_DMA;
                end else begin
                    winner_s = PORT_CPU;
                end
            end
            default: begin
                winner_s = PORT_CPU;
                valid_s  = 1'b0;
            end
        endcase
    end

    assign winner = winner_s;
    assign valid  = valid_s;

    // Track the last grant and count consecutive contested DMA grants under lock.
    always_ff @(posedge clk_mem) begin
        if (!rst_n) begin
            last_grant_r <= PORT_DMA;
            burst_cnt_r  <= {CNT_W{1'b0}};
        end else if (grant_en && valid_s) begin
            last_grant_r <= winner_s;
            if (winner_s == PORT_CPU) begin
                burst_cnt_r <= {CNT_W{1'b0}};
            end else if (dma_lock && req[0]) begin
                // Every contested locked DMA grant counts, so MAX_BURST bounds the run.
                if (burst_cnt_r < CNT_W'(MAX_BURST)) begin
                    burst_cnt_r <= burst_cnt_r + CNT_W'(1);
                end else begin
                    burst_cnt_r <= burst_cnt_r;
                end
            end else begin
                burst_cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares the io_register port between CPU (port 0) and DMA (port 1): one
// transaction at a time, IDLE -> ACCESS -> ACK, three cycles each.
module io_bus_arbiter
    import fgba_io_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk_mem,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [1:0]        cpu_width,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_write,
    input  logic [1:0]        dma_width,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    input  logic              dma_lock,
    output logic [ADDR_W-1:0] io_addr,
    output logic [DATA_W-1:0] io_data_in,
    input  logic [DATA_W-1:0] io_data_out,
    output logic              io_read,
    output logic              io_write,
    output logic [1:0]        io_width,
    output logic              busy
);

    arb_state_t        state_r;
    port_id_t          winner_r;
    logic [ADDR_W-1:0] io_addr_r;
    logic [DATA_W-1:0] io_data_in_r;
    logic              io_read_r;
    logic              io_write_r;
    logic [1:0]        io_width_r;
    logic [DATA_W-1:0] cpu_rdata_r;
    logic [DATA_W-1:0] dma_rdata_r;
    logic              cpu_ack_r;
    logic              dma_ack_r;
    logic              busy_r;

    port_id_t          pick_winner_s;
    logic              pick_valid_s;
    logic              grant_en_s;
    logic              sel_write_s;
    logic [1:0]        sel_width_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    assign grant_en_s = (state_r == ST_IDLE);

    io_rr_pick #(
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .clk_mem  (clk_mem),
        .rst_n    (rst_n),
        .req      ({dma_req, cpu_req}),
        .dma_lock (dma_lock),
        .grant_en (grant_en_s),
        .winner   (pick_winner_s),
        .valid    (pick_valid_s)
    );

    // Route the winning requester's fields toward the io latch.
    always_comb begin
        sel_write_s = cpu_write;
        sel_width_s = cpu_width;
        sel_addr_s  = cpu_addr;
        sel_wdata_s = cpu_wdata;
        if (pick_winner_s == PORT_DMA) begin
            sel_write_s = dma_write;
            sel_width_s = dma_width;
            sel_addr_s  = dma_addr;
            sel_wdata_s = dma_wdata;
        end else begin
            sel_write_s = cpu_write;
            sel_width_s = cpu_width;
            sel_addr_s  = cpu_addr;
            sel_wdata_s = cpu_wdata;
        end
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk_mem) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            winner_r     <= PORT_CPU;
            io_addr_r    <= {ADDR_W{1'b0}};
            io_data_in_r <= {DATA_W{1'b0}};
            io_read_r    <= 1'b0;
            io_write_r   <= 1'b0;
            io_width_r   <= 2'b00;
            cpu_rdata_r  <= {DATA_W{1'b0}};
            dma_rdata_r  <= {DATA_W{1'b0}};
            cpu_ack_r    <= 1'b0;
            dma_ack_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        winner_r     <= pick_winner_s;
                        io_addr_r    <= sel_addr_s;
                        io_data_in_r <= sel_wdata_s;
                        io_width_r   <= sel_width_s;
                        io_read_r    <= !sel_write_s;
                        io_write_r   <= sel_write_s;
                        busy_r       <= 1'b1;
                        state_r      <= ST_ACCESS;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    io_read_r  <= 1'b0;
                    io_write_r <= 1'b0;
                    // io_data_out is combinational of io_addr, so it is valid now.
                    if (io_read_r && (winner_r == PORT_DMA)) begin
                        dma_rdata_r <= io_data_out;
                    end else if (io_read_r) begin
                        cpu_rdata_r <= io_data_out;
                    end
                    cpu_ack_r <= (winner_r == PORT_CPU);
                    dma_ack_r <= (winner_r == PORT_DMA);
                    state_r   <= ST_ACK;
                end
                ST_ACK: begin
                    cpu_ack_r <= 1'b0;
                    dma_ack_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    io_read_r  <= 1'b0;
                    io_write_r <= 1'b0;
                    cpu_ack_r  <= 1'b0;
                    dma_ack_r  <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_addr    = io_addr_r;
    assign io_data_in = io_data_in_r;
    assign io_read    = io_read_r;
    assign io_write   = io_write_r;
    assign io_width   = io_width_r;
    assign cpu_rdata  = cpu_rdata_r;
    assign dma_rdata  = dma_rdata_r;
    assign cpu_ack    = cpu_ack_r;
    assign dma_ack    = dma_ack_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: reset, single accesses, round-robin,
// DMA burst lock, reset mid-access and back-to-back reads.
module tb_io_bus_arbiter;

    logic        clk_mem = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_write, dma_req, dma_write, dma_lock;
    logic [1:0]  cpu_width, dma_width, io_width;
    logic [23:0] cpu_addr, dma_addr, io_addr;
    logic [31:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, io_data_in, io_data_out;
    logic        cpu_ack, dma_ack, io_read, io_write, busy;

    int total = 0;
    int bad   = 0;

    // Register-file stand-in: read data is a fixed function of the address.
    assign io_data_out = {8'h00, io_addr} ^ 32'h00A50004;

    always #5 clk_mem = ~clk_mem;

    io_bus_arbiter #(.ADDR_W(24), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk_mem(clk_mem), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_width(cpu_width), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_write(dma_write), .dma_width(dma_width), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack), .dma_lock(dma_lock),
        .io_addr(io_addr), .io_data_in(io_data_in), .io_data_out(io_data_out),
        .io_read(io_read), .io_write(io_write), .io_width(io_width), .busy(busy)
    );

    task automatic tick();
        @(posedge clk_mem);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (io_read !== 1'b0) begin bad++; $display("FAIL reset_io_read got=%0b exp=0", io_read); end
        total++; if (io_write !== 1'b0) begin bad++; $display("FAIL reset_io_write got=%0b exp=0", io_write); end
        total++; if ({io_addr, io_data_in, io_width} !== 58'd0) begin bad++; $display("FAIL reset_io_fields got=%h/%h/%b exp=0", io_addr, io_data_in, io_width); end
        total++; if ({cpu_rdata, dma_rdata} !== 64'd0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0", cpu_rdata, dma_rdata); end
        total++; if ({cpu_ack, dma_ack, busy} !== 3'b000) begin bad++; $display("FAIL reset_ack_busy got=%b exp=000", {cpu_ack, dma_ack, busy}); end
        rst_n = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_width = 2'b10; cpu_addr = 24'h000004;
        total++; if (io_read !== 1'b0) begin bad++; $display("FAIL rd_c1_io_read got=%0b exp=0", io_read); end
        tick();
        total++; if (io_read !== 1'b1 || io_write !== 1'b0) begin bad++; $display("FAIL rd_c2_strobes got=%0b%0b exp=10", io_read, io_write); end
        total++; if (io_addr !== 24'h000004) begin bad++; $display("FAIL rd_c2_addr got=%h exp=000004", io_addr); end
        total++; if (busy !== 1'b1 || cpu_ack !== 1'b0) begin bad++; $display("FAIL rd_c2_busy_ack got=%0b%0b exp=10", busy, cpu_ack); end
        tick();
        total++; if (io_read !== 1'b0) begin bad++; $display("FAIL rd_c3_io_read got=%0b exp=0", io_read); end
        total++; if (cpu_ack !== 1'b1 || dma_ack !== 1'b0) begin bad++; $display("FAIL rd_c3_ack got=%0b%0b exp=10", cpu_ack, dma_ack); end
        total++; if (cpu_rdata !== 32'h00A50000) begin bad++; $display("FAIL rd_rdata got=%h exp=00a50000", cpu_rdata); end
        cpu_req = 1'b0;
        tick();
        total++; if (cpu_ack !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rd_c4_done got=%0b%0b exp=00", cpu_ack, busy); end
        total++; if (cpu_rdata !== 32'h00A50000) begin bad++; $display("FAIL rd_rdata_hold got=%h exp=00a50000", cpu_rdata); end
    endtask

    task automatic test_cpu_write();
        cpu_req = 1'b1; cpu_write = 1'b1; cpu_width = 2'b01; cpu_addr = 24'h000400; cpu_wdata = 32'h000001FF;
        tick();
        total++; if (io_write !== 1'b1 || io_read !== 1'b0) begin bad++; $display("FAIL wr_strobes got=%0b%0b exp=10", io_write, io_read); end
        total++; if (io_addr !== 24'h000400 || io_data_in !== 32'h000001FF) begin bad++; $display("FAIL wr_fields got=%h/%h exp=000400/000001ff", io_addr, io_data_in); end
        total++; if (io_width !== 2'b01) begin bad++; $display("FAIL wr_width got=%b exp=01", io_width); end
        tick();
        total++; if (io_write !== 1'b0) begin bad++; $display("FAIL wr_one_cycle got=%0b exp=0", io_write); end
        total++; if (cpu_ack !== 1'b1 || dma_ack !== 1'b0) begin bad++; $display("FAIL wr_ack got=%0b%0b exp=10", cpu_ack, dma_ack); end
        total++; if (cpu_rdata !== 32'h00A50000) begin bad++; $display("FAIL wr_rdata_unchanged got=%h exp=00a50000", cpu_rdata); end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic exp_dma;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 24'h000010;
        dma_req = 1'b1; dma_write = 1'b1; dma_addr = 24'h000020; dma_lock = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_dma = (k % 2 == 1);
            tick();
            total++; if (io_addr !== (exp_dma ? 24'h000020 : 24'h000010)) begin bad++; $display("FAIL rr_addr grant=%0d got=%h exp_dma=%0b", k, io_addr, exp_dma); end
            tick();
            total++; if (cpu_ack !== !exp_dma || dma_ack !== exp_dma) begin bad++; $display("FAIL rr_ack grant=%0d got=%0b%0b exp_dma=%0b", k, cpu_ack, dma_ack, exp_dma); end
            tick();
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        tick();
    endtask

    task automatic test_burst();
        logic [5:0] pat;
        logic       exp_dma;
        pat = 6'b101111;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cpu_req = 1'b0; cpu_write = 1'b1; cpu_addr = 24'h000010;
        dma_req = 1'b1; dma_write = 1'b1; dma_addr = 24'h000030; dma_lock = 1'b1;
        tick();
        total++; if (io_addr !== 24'h000030) begin bad++; $display("FAIL burst_first_addr got=%h exp=000030", io_addr); end
        cpu_req = 1'b1;
        tick();
        total++; if (dma_ack !== 1'b1) begin bad++; $display("FAIL burst_first_ack got=%0b exp=1", dma_ack); end
        tick();
        for (int k = 0; k < 6; k++) begin
            exp_dma = pat[k];
            tick();
            total++; if (io_addr !== (exp_dma ? 24'h000030 : 24'h000010)) begin bad++; $display("FAIL burst_addr grant=%0d got=%h exp_dma=%0b", k, io_addr, exp_dma); end
            tick();
            total++; if (cpu_ack !== !exp_dma || dma_ack !== exp_dma) begin bad++; $display("FAIL burst_ack grant=%0d got=%0b%0b exp_dma=%0b", k, cpu_ack, dma_ack, exp_dma); end
            tick();
        end
        cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_access();
        cpu_req = 1'b1; cpu_write = 1'b1; cpu_width = 2'b10; cpu_addr = 24'h000404; cpu_wdata = 32'h0000DEAD;
        tick();
        total++; if (io_write !== 1'b1 || io_addr !== 24'h000404) begin bad++; $display("FAIL rstacc_write got=%0b/%h exp=1/000404", io_write, io_addr); end
        rst_n = 1'b0;
        tick();
        total++; if ({io_write, io_read, io_addr, io_data_in, io_width} !== 60'd0) begin bad++; $display("FAIL rstacc_io_cleared got=%0b%0b/%h/%h/%b exp=0", io_write, io_read, io_addr, io_data_in, io_width); end
        total++; if ({cpu_ack, dma_ack, busy} !== 3'b000) begin bad++; $display("FAIL rstacc_ack_busy got=%b exp=000", {cpu_ack, dma_ack, busy}); end
        total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL rstacc_rdata got=%h exp=0", cpu_rdata); end
        cpu_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (cpu_ack !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstacc_no_ack got=%0b%0b exp=00", cpu_ack, busy); end
    endtask

    task automatic test_back_to_back();
        dma_req = 1'b1; dma_write = 1'b0; dma_width = 2'b10; dma_addr = 24'h000100;
        tick();
        total++; if (io_read !== 1'b1 || io_addr !== 24'h000100) begin bad++; $display("FAIL b2b_first got=%0b/%h exp=1/000100", io_read, io_addr); end
        tick();
        total++; if (dma_ack !== 1'b1 || dma_rdata !== 32'h00A50104) begin bad++; $display("FAIL b2b_first_ack got=%0b/%h exp=1/00a50104", dma_ack, dma_rdata); end
        total++; if (cpu_ack !== 1'b0 || cpu_rdata !== 32'h0) begin bad++; $display("FAIL b2b_cpu_quiet got=%0b/%h exp=0/0", cpu_ack, cpu_rdata); end
        dma_addr = 24'h000200;
        tick();
        total++; if (io_read !== 1'b0 || dma_ack !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%0b%0b exp=00", io_read, dma_ack); end
        tick();
        total++; if (io_read !== 1'b1 || io_addr !== 24'h000200) begin bad++; $display("FAIL b2b_second got=%0b/%h exp=1/000200", io_read, io_addr); end
        tick();
        total++; if (dma_ack !== 1'b1 || dma_rdata !== 32'h00A50204) begin bad++; $display("FAIL b2b_second_ack got=%0b/%h exp=1/00a50204", dma_ack, dma_rdata); end
        dma_req = 1'b0;
        tick();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0b exp=0", busy); end
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_write = 1'b0; cpu_width = 2'b00; cpu_addr = 24'h0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_write = 1'b0; dma_width = 2'b00; dma_addr = 24'h0; dma_wdata = 32'h0;
        dma_lock = 1'b0;
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_round_robin();
        test_burst();
        test_reset_in_access();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
